// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry result slot per functional unit, round-robin grant,
// and a registered single-cycle CDB broadcast.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DATA_W  = 32,
  localparam int unsigned SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_value_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      flush_i,
  output logic                      cdb_valid_o,
  output logic [TAG_W-1:0]          cdb_tag_o,
  output logic [DATA_W-1:0]         cdb_value_o,
  output logic [SRC_W-1:0]          cdb_src_o
);

  logic [NUM_REQ-1:0] slot_valid_q, slot_valid_d;
  logic [TAG_W-1:0]   slot_tag_q   [NUM_REQ];
  logic [DATA_W-1:0]  slot_value_q [NUM_REQ];
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]  cdb_value_q, cdb_value_d;
  logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

  logic [NUM_REQ-1:0] grant;
  logic               grant_found;
  logic [SRC_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] load;

  // Rotating priority search starting at rr_ptr_q; flush suppresses any grant.
  always_comb begin
    int unsigned      idx;
    logic [SRC_W-1:0] idx_s;
    grant       = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_s       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_s = SRC_W'(idx);
      if (!grant_found && !flush_i && slot_valid_q[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
        grant_found  = 1'b1;
      end
    end
  end

  // A slot being granted this cycle frees up and may reload on the same edge.
  always_comb begin
    req_ready_o = flush_i ? '0 : (~slot_valid_q | grant);
    load        = req_valid_i & req_ready_o;
  end

  always_comb begin
    slot_valid_d = '0;
    if (!flush_i) begin
      slot_valid_d = (slot_valid_q & ~grant) | load;
    end
  end

  always_comb begin
    int unsigned nxt;
    nxt         = 32'(grant_idx) + 1;
    if (nxt >= NUM_REQ) begin
      nxt = 0;
    end
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_src_d   = cdb_src_q;
    if (grant_found) begin
      rr_ptr_d    = SRC_W'(nxt);
      cdb_valid_d = 1'b1;
      cdb_tag_d   = slot_tag_q[grant_idx];
      cdb_value_d = slot_value_q[grant_idx];
      cdb_src_d   = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_value_q  <= cdb_value_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  // Slot payload is qualified by slot_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (load[i]) begin
        slot_tag_q[i]   <= req_tag_i[i*TAG_W +: TAG_W];
        slot_value_q[i] <= req_value_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_tag_o   = cdb_tag_q;
  assign cdb_value_o = cdb_value_q;
  assign cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, contention/reset sequences,
// and randomized traffic against a slot-level reference model.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [15:0]  req_tag;
  logic [127:0] req_value;
  logic [3:0]   req_ready;
  logic         flush;
  logic         cdb_valid;
  logic [3:0]   cdb_tag;
  logic [31:0]  cdb_value;
  logic [1:0]   cdb_src;

  int tests = 0;
  int fails = 0;

  cdb_arbiter #(
    .NUM_REQ(4),
    .TAG_W  (4),
    .DATA_W (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid),
    .req_tag_i  (req_tag),
    .req_value_i(req_value),
    .req_ready_o(req_ready),
    .flush_i    (flush),
    .cdb_valid_o(cdb_valid),
    .cdb_tag_o  (cdb_tag),
    .cdb_value_o(cdb_value),
    .cdb_src_o  (cdb_src)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic        fl;
    logic [3:0]  v;
    logic [15:0] tags;
    logic [31:0] base;
    logic [3:0]  er;
    logic        ev;
    logic [1:0]  es;
    logic [3:0]  et;
    logic [31:0] eval;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Unit i presents value base + i.
  task automatic drive(input logic fl, input logic [3:0] v, input logic [15:0] tags,
                       input logic [31:0] base);
    flush     = fl;
    req_valid = v;
    req_tag   = tags;
    req_value = {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endtask

  task automatic chk_cdb(input string nm, input logic ev, input logic [1:0] es,
                         input logic [3:0] et, input logic [31:0] eval);
    chk({nm, " cdb_valid"}, 32'(cdb_valid), 32'(ev));
    chk({nm, " cdb_src"}, 32'(cdb_src), 32'(es));
    chk({nm, " cdb_tag"}, 32'(cdb_tag), 32'(et));
    chk({nm, " cdb_value"}, cdb_value, eval);
  endtask

  // Reference model state
  bit          pend [4];
  logic [3:0]  ptag [4];
  logic [31:0] pval [4];
  int          ptr;
  logic        mv;
  logic [3:0]  mt;
  logic [31:0] md;
  int          ms;

  logic        cv [4];
  logic [3:0]  ct [4];
  logic [31:0] cd [4];
  logic        lacc [4];

  initial begin
    // fl, valid, tags, base, exp_ready, exp_cdb_valid, exp_src, exp_tag, exp_value
    vecs[0]  = '{1'b0, 4'b0100, 16'h0500, 32'hDEADBEED, 4'b1111, 1'b0, 2'd0, 4'h0, 32'h0};
    vecs[1]  = '{1'b0, 4'b0000, 16'h0000, 32'h0, 4'b1111, 1'b1, 2'd2, 4'h5, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 4'b0000, 16'h0000, 32'h0, 4'b1111, 1'b0, 2'd2, 4'h5, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 4'b1001, 16'h9007, 32'hB0000000, 4'b1111, 1'b0, 2'd2, 4'h5, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 4'b0000, 16'h0000, 32'h0, 4'b1110, 1'b1, 2'd3, 4'h9, 32'hB0000003};
    vecs[5]  = '{1'b0, 4'b0000, 16'h0000, 32'h0, 4'b1111, 1'b1, 2'd0, 4'h7, 32'hB0000000};
    vecs[6]  = '{1'b0, 4'b0000, 16'h0000, 32'h0, 4'b1111, 1'b0, 2'd0, 4'h7, 32'hB0000000};
    vecs[7]  = '{1'b0, 4'b0110, 16'h0BA0, 32'hC0000000, 4'b1111, 1'b0, 2'd0, 4'h7, 32'hB0000000};
    vecs[8]  = '{1'b0, 4'b0100, 16'h0D00, 32'hD0000000, 4'b1011, 1'b1, 2'd1, 4'hA, 32'hC0000001};
    vecs[9]  = '{1'b0, 4'b0100, 16'h0D00, 32'hD0000000, 4'b1111, 1'b1, 2'd2, 4'hB, 32'hC0000002};
    vecs[10] = '{1'b0, 4'b0000, 16'h0000, 32'h0, 4'b1111, 1'b1, 2'd2, 4'hD, 32'hD0000002};
    vecs[11] = '{1'b0, 4'b0000, 16'h0000, 32'h0, 4'b1111, 1'b0, 2'd2, 4'hD, 32'hD0000002};
    vecs[12] = '{1'b0, 4'b1011, 16'h4021, 32'hE0000000, 4'b1111, 1'b0, 2'd2, 4'hD, 32'hD0000002};
    vecs[13] = '{1'b0, 4'b0100, 16'h0300, 32'hE0000000, 4'b1100, 1'b1, 2'd3, 4'h4, 32'hE0000003};
    vecs[14] = '{1'b1, 4'b1111, 16'hFFFF, 32'hF0000000, 4'b0000, 1'b0, 2'd3, 4'h4, 32'hE0000003};
    vecs[15] = '{1'b0, 4'b0000, 16'h0000, 32'h0, 4'b1111, 1'b0, 2'd3, 4'h4, 32'hE0000003};
    vecs[16] = '{1'b0, 4'b0000, 16'h0000, 32'h0, 4'b1111, 1'b0, 2'd3, 4'h4, 32'hE0000003};
    vecs[17] = '{1'b0, 4'b1010, 16'h8060, 32'h10000000, 4'b1111, 1'b0, 2'd3, 4'h4, 32'hE0000003};
    vecs[18] = '{1'b0, 4'b0000, 16'h0000, 32'h0, 4'b0111, 1'b1, 2'd1, 4'h6, 32'h10000001};
    vecs[19] = '{1'b0, 4'b0000, 16'h0000, 32'h0, 4'b1111, 1'b1, 2'd3, 4'h8, 32'h10000003};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 4'b0000, 16'h0, 32'h0);
    #1;
    chk("reset ready", 32'(req_ready), 32'hF);
    chk_cdb("reset", 1'b0, 2'd0, 4'h0, 32'h0);
    flush = 1'b1;
    #1;
    chk("reset flush ready", 32'(req_ready), 32'h0);
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int k = 0; k < 20; k++) begin
      drive(vecs[k].fl, vecs[k].v, vecs[k].tags, vecs[k].base);
      #1;
      chk($sformatf("vec%0d ready", k), 32'(req_ready), 32'(vecs[k].er));
      @(posedge clk);
      #1;
      chk_cdb($sformatf("vec%0d", k), vecs[k].ev, vecs[k].es, vecs[k].et, vecs[k].eval);
    end

    // Full contention from reset
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 4'b1111, 16'h4321, 32'h50000000);
      #1;
      chk($sformatf("cont%0d ready", c), 32'(req_ready),
          (c == 0) ? 32'hF : (32'd1 << ((c - 1) % 4)));
      @(posedge clk);
      #1;
      if (c == 0) begin
        chk("cont0 cdb_valid", 32'(cdb_valid), 32'd0);
      end else begin
        chk_cdb($sformatf("cont%0d", c), 1'b1, 2'((c - 1) % 4), 4'(((c - 1) % 4) + 1),
                32'h50000000 + 32'((c - 1) % 4));
      end
    end

    // Async reset between edges under contention
    #3;
    rst_n = 1'b0;
    #1;
    chk_cdb("async rst", 1'b0, 2'd0, 4'h0, 32'h0);
    chk("async rst ready", 32'(req_ready), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst first edge valid", 32'(cdb_valid), 32'd0);
    @(posedge clk);
    #1;
    chk_cdb("post rst first grant", 1'b1, 2'd0, 4'h1, 32'h50000000);

    // Randomized traffic against the reference model
    #2;
    rst_n = 1'b0;
    drive(1'b0, 4'b0000, 16'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0; ptag[i] = '0; pval[i] = '0;
      cv[i] = 1'b0; ct[i] = '0; cd[i] = '0; lacc[i] = 1'b0;
    end
    ptr = 0; mv = 1'b0; mt = '0; md = '0; ms = 0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic       fl;
      logic [3:0] er;
      int         win;
      for (int i = 0; i < 4; i++) begin
        // A blocked request stays put, apart from an occasional legal withdrawal.
        if (!(cv[i] && !lacc[i] && $urandom_range(7) != 0)) begin
          cv[i] = ($urandom_range(2) != 0);
          ct[i] = 4'($urandom);
          cd[i] = $urandom;
        end
      end
      fl = ($urandom_range(19) == 0);
      flush     = fl;
      req_valid = {cv[3], cv[2], cv[1], cv[0]};
      req_tag   = {ct[3], ct[2], ct[1], ct[0]};
      req_value = {cd[3], cd[2], cd[1], cd[0]};

      win = -1;
      if (!fl) begin
        for (int k = 0; k < 4; k++) begin
          if (win < 0 && pend[(ptr + k) % 4]) win = (ptr + k) % 4;
        end
      end
      for (int i = 0; i < 4; i++) er[i] = !fl && (!pend[i] || win == i);
      #1;
      chk("rand ready", 32'(req_ready), 32'(er));
      @(posedge clk);

      if (fl) begin
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        mv = 1'b0;
      end else begin
        if (win >= 0) begin
          mv = 1'b1; mt = ptag[win]; md = pval[win]; ms = win;
          pend[win] = 1'b0;
          ptr = (win + 1) % 4;
        end else begin
          mv = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
          if (cv[i] && er[i]) begin
            pend[i] = 1'b1; ptag[i] = ct[i]; pval[i] = cd[i];
          end
        end
      end
      for (int i = 0; i < 4; i++) lacc[i] = cv[i] && er[i];
      #1;
      chk_cdb("rand", mv, 2'(ms), mt, md);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
